// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and forwarding control for the 5-stage integer pipeline.
// Optional macro FORWARDING_EN enables EX/MEM operand bypassing (load-use becomes the only stall).
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_writes_rd,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

`ifdef FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t            state_r;
  logic              ex_valid_r;
  logic [REG_AW-1:0] ex_rd_r;
  logic              ex_load_r;
  logic              mem_valid_r;
  logic [REG_AW-1:0] mem_rd_r;
  logic [1:0]        fwd_a_r;
  logic [1:0]        fwd_b_r;
  logic [CNT_W-1:0]  stall_count_r;
  logic [CNT_W-1:0]  flush_count_r;

  logic              rs1_ex_s;
  logic              rs2_ex_s;
  logic              rs1_mem_s;
  logic              rs2_mem_s;
  logic              hazard_s;
  logic              stall_s;
  logic              flush_s;
  logic              issue_s;
  logic              id_wr_s;
  logic [1:0]        sel_a_s;
  logic [1:0]        sel_b_s;

  // The WB stage is not tracked: the register file bypasses same-cycle writes,
  // and a MEM entry's load flag never matters, so neither is stored.

  // Source/producer matching, hazard decision and next forwarding selects
  always_comb begin
    rs1_ex_s  = id_uses_rs1 & ex_valid_r  & (id_rs1 == ex_rd_r);
    rs2_ex_s  = id_uses_rs2 & ex_valid_r  & (id_rs2 == ex_rd_r);
    rs1_mem_s = id_uses_rs1 & mem_valid_r & (id_rs1 == mem_rd_r);
    rs2_mem_s = id_uses_rs2 & mem_valid_r & (id_rs2 == mem_rd_r);
    hazard_s  = ((rs1_ex_s | rs2_ex_s) & (ex_load_r | ~FWD_EN)) |
                ((rs1_mem_s | rs2_mem_s) & ~FWD_EN);
    stall_s   = ~reset & id_valid & hazard_s & ~ex_branch_taken;
    flush_s   = ~reset & ex_branch_taken;
    issue_s   = id_valid & ~stall_s & ~flush_s;
    id_wr_s   = id_valid & id_writes_rd & (id_rd != {REG_AW{1'b0}});
    if (rs1_ex_s) begin
      sel_a_s = 2'b01;
    end else if (rs1_mem_s) begin
      sel_a_s = 2'b10;
    end else begin
      sel_a_s = 2'b00;
    end
    if (rs2_ex_s) begin
      sel_b_s = 2'b01;
    end else if (rs2_mem_s) begin
      sel_b_s = 2'b10;
    end else begin
      sel_b_s = 2'b00;
    end
  end

  assign stall_if_id  = stall_s;
  assign bubble_id_ex = stall_s | flush_s;
  assign flush_if_id  = flush_s;
  assign fwd_a_sel    = fwd_a_r;
  assign fwd_b_sel    = fwd_b_r;
  assign state        = state_r;
  assign stall_count  = stall_count_r;
  assign flush_count  = flush_count_r;

  // In-flight destination tracking and registered forwarding selects
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_r  <= 1'b0;
      ex_rd_r     <= {REG_AW{1'b0}};
      ex_load_r   <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_rd_r    <= {REG_AW{1'b0}};
      fwd_a_r     <= 2'b00;
      fwd_b_r     <= 2'b00;
    end else begin
      mem_valid_r <= ex_valid_r;
      mem_rd_r    <= ex_rd_r;
      if (issue_s) begin
        ex_valid_r <= id_wr_s;
        ex_rd_r    <= id_rd;
        ex_load_r  <= id_is_load;
        fwd_a_r    <= FWD_EN ? sel_a_s : 2'b00;
        fwd_b_r    <= FWD_EN ? sel_b_s : 2'b00;
      end else begin
        ex_valid_r <= 1'b0;
        ex_rd_r    <= {REG_AW{1'b0}};
        ex_load_r  <= 1'b0;
        fwd_a_r    <= 2'b00;
        fwd_b_r    <= 2'b00;
      end
    end
  end

  // Control state: a taken branch outranks any stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (1'b1)
        flush_s: state_r <= ST_FLUSH;
        stall_s: state_r <= ST_STALL;
        default: state_r <= ST_RUN;
      endcase
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= {CNT_W{1'b0}};
      flush_count_r <= {CNT_W{1'b0}};
    end else begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, stall_s};
      flush_count_r <= flush_count_r + {{(CNT_W-1){1'b0}}, flush_s};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expectations follow FORWARDING_EN.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load;
  logic        ex_branch_taken;
  logic        stall_if_id, bubble_id_ex, flush_if_id;
  logic [1:0]  fwd_a_sel, fwd_b_sel, state;
  logic [31:0] stall_count, flush_count;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_writes_rd(id_writes_rd), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                     input logic wr, input logic ld, input logic br);
    id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    id_rd = rd; id_writes_rd = wr; id_is_load = ld; ex_branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input string tag, input logic s, input logic b, input logic f);
    @(negedge clk);
    chk({tag, "_stall"},  {31'd0, stall_if_id},  {31'd0, s});
    chk({tag, "_bubble"}, {31'd0, bubble_id_ex}, {31'd0, b});
    chk({tag, "_flush"},  {31'd0, flush_if_id},  {31'd0, f});
  endtask

  task automatic idle(input int n);
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    // Reset cycle with a taken branch pending: combinational outputs must stay low
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    comb("rst_comb", 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    idle(0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
    chk("rst_scnt", stall_count, 32'd0);
    chk("rst_fcnt", flush_count, 32'd0);
    comb("idle", 1'b0, 1'b0, 1'b0);

    // add x5 ; add x6,x5,x1
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    comb("p5", 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef FORWARDING_EN
    comb("exfwd", 1'b0, 1'b0, 1'b0);
    tick();
    chk("exfwd_a", {30'd0, fwd_a_sel}, 32'd1);
    chk("exfwd_b", {30'd0, fwd_b_sel}, 32'd0);
`else
    comb("raw_ex1", 1'b1, 1'b1, 1'b0);
    tick(); exp_stall++;
    chk("raw_ex1_st", {30'd0, state}, 32'd1);
    comb("raw_ex2", 1'b1, 1'b1, 1'b0);
    tick(); exp_stall++;
    chk("raw_ex2_st", {30'd0, state}, 32'd1);
    comb("raw_ex3", 1'b0, 1'b0, 1'b0);
    tick();
    chk("raw_ex_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
`endif
    chk("raw_ex_run", {30'd0, state}, 32'd0);
    chk("raw_ex_scnt", stall_count, exp_stall);

    // Independent add x9 between producer x6 and consumer add x10,x6,x1
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    comb("indep", 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
`ifdef FORWARDING_EN
    comb("memfwd", 1'b0, 1'b0, 1'b0);
    tick();
    chk("memfwd_a", {30'd0, fwd_a_sel}, 32'd2);
    chk("memfwd_b", {30'd0, fwd_b_sel}, 32'd0);
`else
    comb("raw_mem1", 1'b1, 1'b1, 1'b0);
    tick(); exp_stall++;
    chk("raw_mem1_st", {30'd0, state}, 32'd1);
    comb("raw_mem2", 1'b0, 1'b0, 1'b0);
    tick();
    chk("raw_mem_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
`endif
    chk("raw_mem_scnt", stall_count, exp_stall);

    // lw x7 ; add x8,x7,x7
    idle(2);
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    comb("lw", 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    comb("ldu1", 1'b1, 1'b1, 1'b0);
    tick(); exp_stall++;
    chk("ldu1_st", {30'd0, state}, 32'd1);
`ifdef FORWARDING_EN
    comb("ldu2", 1'b0, 1'b0, 1'b0);
    tick();
    chk("ldu_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
    chk("ldu_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
`else
    comb("ldu2", 1'b1, 1'b1, 1'b0);
    tick(); exp_stall++;
    comb("ldu3", 1'b0, 1'b0, 1'b0);
    tick();
    chk("ldu_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("ldu_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
`endif
    chk("ldu_run", {30'd0, state}, 32'd0);
    chk("ldu_scnt", stall_count, exp_stall);

    // Producer writes x0, consumer reads x0
    idle(2);
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    comb("x0", 1'b0, 1'b0, 1'b0);
    tick();
    chk("x0_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("x0_fwd_b", {30'd0, fwd_b_sel}, 32'd0);

    // Taken branch in the same cycle as a load-use hazard
    idle(2);
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    comb("br", 1'b0, 1'b1, 1'b1);
    tick(); exp_flush++;
    chk("br_state", {30'd0, state}, 32'd2);
    chk("br_fcnt", flush_count, exp_flush);
    chk("br_scnt", stall_count, exp_stall);
    chk("br_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    idle(0);
    comb("br_after", 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_run", {30'd0, state}, 32'd0);
    chk("br_fcnt2", flush_count, exp_flush);

    // Reset asserted mid-stall
    idle(1);
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    comb("mrs1", 1'b1, 1'b1, 1'b0);
    tick(); exp_stall++;
    chk("mrs_st", {30'd0, state}, 32'd1);
    chk("mrs_scnt", stall_count, exp_stall);
    reset = 1'b1;
    comb("mrs_rst", 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("mrs_state", {30'd0, state}, 32'd0);
    chk("mrs_scnt0", stall_count, 32'd0);
    chk("mrs_fcnt0", flush_count, 32'd0);
    comb("mrs_clear", 1'b0, 1'b0, 1'b0);
    tick();
    chk("mrs_fwd_a", {30'd0, fwd_a_sel}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
